// File: rtl/filter_pkg.sv
// Shared definitions for the spatial filter datapath: default operand
// widths, default kernel size and the ceiling-log2 helper used to size
// accumulators and counters.
package filter_pkg;

    localparam int DEF_A_W  = 25;
    localparam int DEF_B_W  = 18;
    localparam int DEF_TAPS = 9;

    // Smallest r with 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_acc_pipe_if.sv
// Sample/result bundle of the multiply-accumulate unit. The master side
// (window generator) drives operands; the slave side (the MAC) returns
// products and kernel sums.
interface mult_acc_pipe_if
    import filter_pkg::*;
#(
    parameter int A_W  = DEF_A_W,
    parameter int B_W  = DEF_B_W,
    parameter int TAPS = DEF_TAPS
);
    localparam int P_W   = A_W + B_W;
    localparam int ACC_W = P_W + clog2(TAPS);

    logic [A_W-1:0]   A_IN;
    logic [B_W-1:0]   B_IN;
    logic             VALID_IN;
    logic             CLR_IN;
    logic [P_W-1:0]   PROD_OUT;
    logic             PROD_VALID;
    logic [ACC_W-1:0] ACC_OUT;
    logic             ACC_VALID;

    modport master (
        output A_IN, B_IN, VALID_IN, CLR_IN,
        input  PROD_OUT, PROD_VALID, ACC_OUT, ACC_VALID
    );

    modport slave (
        input  A_IN, B_IN, VALID_IN, CLR_IN,
        output PROD_OUT, PROD_VALID, ACC_OUT, ACC_VALID
    );

endinterface

// File: rtl/mult_core_pipe.sv
// Pipelined exact multiplier: stage 1 registers operands, stage 2 holds the
// product, stages 3..PIPE_STAGES retime it. Valid and window-clear travel in
// shift registers beside the data. Data stages only load when their valid
// advances, so the output holds its last product through bubbles.
module mult_core_pipe #(
    parameter int A_W         = 25,
    parameter int B_W         = 18,
    parameter int SIGNED      = 0,
    parameter int PIPE_STAGES = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [A_W-1:0]       a_i,
    input  logic [B_W-1:0]       b_i,
    input  logic                 valid_i,
    input  logic                 clr_i,
    output logic [A_W+B_W-1:0]   prod_o,
    output logic                 prod_vld_o,
    output logic                 prod_clr_o
);
    localparam int P_W = A_W + B_W;

    logic        [A_W-1:0]   a_p1_q;
    logic        [B_W-1:0]   b_p1_q;
    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [P_W-1:0]   prod_d;
    logic signed [P_W-1:0]   prod_q [2:PIPE_STAGES];
    logic [PIPE_STAGES:1]    vld_q;
    logic [PIPE_STAGES:1]    clr_q;

    function automatic logic signed [P_W-1:0] ext_a(input logic [A_W-1:0] v);
        if (SIGNED != 0) return P_W'($signed(v));
        else             return P_W'(v);
    endfunction

    function automatic logic signed [P_W-1:0] ext_b(input logic [B_W-1:0] v);
        if (SIGNED != 0) return P_W'($signed(v));
        else             return P_W'(v);
    endfunction

    // Operands extended to the full product width, so the P_W-bit product is exact.
    always_comb begin
        a_ext  = ext_a(a_p1_q);
        b_ext  = ext_b(b_p1_q);
        prod_d = a_ext * b_ext;
    end

    // Stage 1 operand capture plus valid/clear sideband shift registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_p1_q <= '0;
            b_p1_q <= '0;
            vld_q  <= '0;
            clr_q  <= '0;
        end else begin
            if (valid_i) begin
                a_p1_q <= a_i;
                b_p1_q <= b_i;
            end
            vld_q <= {vld_q[PIPE_STAGES-1:1], valid_i};
            clr_q <= {clr_q[PIPE_STAGES-1:1], valid_i & clr_i};
        end
    end

    // Stage 2 product register and stages 3..PIPE_STAGES retiming.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            if (vld_q[1]) prod_q[2] <= prod_d;
            for (int k = 3; k <= PIPE_STAGES; k++) begin
                if (vld_q[k-1]) prod_q[k] <= prod_q[k-1];
            end
        end
    end

    assign prod_o     = prod_q[PIPE_STAGES];
    assign prod_vld_o = vld_q[PIPE_STAGES];
    assign prod_clr_o = clr_q[PIPE_STAGES];

endmodule

// File: rtl/mult_acc_pipe.sv
// Multiply-accumulate unit for the spatial filter: the core pipeline forms
// exact products, this level sums TAPS consecutive valid products into one
// kernel result, with window restart on a delayed clear.
module mult_acc_pipe
    import filter_pkg::*;
#(
    parameter int A_W         = DEF_A_W,
    parameter int B_W         = DEF_B_W,
    parameter int SIGNED      = 0,
    parameter int PIPE_STAGES = 3,
    parameter int TAPS        = DEF_TAPS
) (
    input  logic             CLK,
    input  logic             RST,
    mult_acc_pipe_if.slave   bus
);
    localparam int P_W   = A_W + B_W;
    localparam int ACC_W = P_W + clog2(TAPS);
    localparam int CNT_W = clog2(TAPS) + 1;

    logic [P_W-1:0]          prod;
    logic                    prod_vld;
    logic                    prod_clr;

    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic signed [ACC_W-1:0] sum_q,     sum_d;
    logic signed [ACC_W-1:0] acc_q,     acc_d;
    logic                    acc_vld_q, acc_vld_d;
    logic signed [ACC_W-1:0] base;
    logic [CNT_W-1:0]        next_cnt;

    function automatic logic signed [ACC_W-1:0] ext_p(input logic [P_W-1:0] v);
        if (SIGNED != 0) return ACC_W'($signed(v));
        else             return ACC_W'(v);
    endfunction

    mult_core_pipe #(
        .A_W         (A_W),
        .B_W         (B_W),
        .SIGNED      (SIGNED),
        .PIPE_STAGES (PIPE_STAGES)
    ) u_core (
        .CLK        (CLK),
        .RST        (RST),
        .a_i        (bus.A_IN),
        .b_i        (bus.B_IN),
        .valid_i    (bus.VALID_IN),
        .clr_i      (bus.CLR_IN),
        .prod_o     (prod),
        .prod_vld_o (prod_vld),
        .prod_clr_o (prod_clr)
    );

    // Window sum: restart on tap 0 or clear, publish and rewind when the last tap lands.
    always_comb begin
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        acc_d     = acc_q;
        acc_vld_d = 1'b0;
        base      = '0;
        next_cnt  = '0;
        if (prod_vld) begin
            if (cnt_q == '0 || prod_clr) begin
                base     = ext_p(prod);
                next_cnt = CNT_W'(1);
            end else begin
                base     = sum_q + ext_p(prod);
                next_cnt = cnt_q + CNT_W'(1);
            end
            if (next_cnt == CNT_W'(TAPS)) begin
                acc_d     = base;
                acc_vld_d = 1'b1;
                cnt_d     = '0;
            end else begin
                sum_d = base;
                cnt_d = next_cnt;
            end
        end
    end

    // Accumulator state and registered kernel result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            sum_q     <= '0;
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            acc_q     <= acc_d;
            acc_vld_q <= acc_vld_d;
        end
    end

    assign bus.PROD_OUT   = prod;
    assign bus.PROD_VALID = prod_vld;
    assign bus.ACC_OUT    = acc_q;
    assign bus.ACC_VALID  = acc_vld_q;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Scoreboard bench: an unsigned and a signed instance see identical stimulus;
// a reference model queues expected products and window sums, and a monitor
// on the falling edge pops and compares whenever the DUTs present results.
module tb_mult_acc_pipe;

    localparam int A_W   = 25;
    localparam int B_W   = 18;
    localparam int P_W   = 43;
    localparam int TAPS  = 9;
    localparam int ACC_W = 47;
    localparam int PIPE  = 3;

    localparam logic [63:0] PM = (64'd1 << P_W) - 64'd1;
    localparam logic [63:0] AM = (64'd1 << ACC_W) - 64'd1;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mult_acc_pipe_if #(.A_W(A_W), .B_W(B_W), .TAPS(TAPS)) bu ();
    mult_acc_pipe_if #(.A_W(A_W), .B_W(B_W), .TAPS(TAPS)) bs ();

    mult_acc_pipe #(.A_W(A_W), .B_W(B_W), .SIGNED(0), .PIPE_STAGES(PIPE), .TAPS(TAPS))
        dut_u (.CLK(CLK), .RST(RST), .bus(bu.slave));
    mult_acc_pipe #(.A_W(A_W), .B_W(B_W), .SIGNED(1), .PIPE_STAGES(PIPE), .TAPS(TAPS))
        dut_s (.CLK(CLK), .RST(RST), .bus(bs.slave));

    int n_checks = 0;
    int n_fail   = 0;

    longint eq_pu[$], eq_ps[$], eq_au[$], eq_as[$];
    longint win_u[$], win_s[$];
    logic [63:0] last_pu = '0, last_ps = '0, last_au = '0, last_as = '0;

    function automatic longint sx(longint v, int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        if (v[w-1]) return v - m;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: products as plain integers, a window is a list of products.
    task automatic model_sample(logic [A_W-1:0] a, logic [B_W-1:0] b, bit c);
        longint pu, ps, su, ss;
        pu = longint'(a) * longint'(b);
        ps = sx(longint'(a), A_W) * sx(longint'(b), B_W);
        eq_pu.push_back(pu);
        eq_ps.push_back(ps);
        if (c) begin
            win_u.delete();
            win_s.delete();
        end
        win_u.push_back(pu);
        win_s.push_back(ps);
        if (win_u.size() == TAPS) begin
            su = 0;
            ss = 0;
            foreach (win_u[i]) begin
                su += win_u[i];
                ss += win_s[i];
            end
            eq_au.push_back(su);
            eq_as.push_back(ss);
            win_u.delete();
            win_s.delete();
        end
    endtask

    task automatic flush_model();
        eq_pu.delete(); eq_ps.delete(); eq_au.delete(); eq_as.delete();
        win_u.delete(); win_s.delete();
        last_pu = '0; last_ps = '0; last_au = '0; last_as = '0;
    endtask

    task automatic set_inputs(logic [A_W-1:0] a, logic [B_W-1:0] b, bit v, bit c);
        bu.A_IN = a; bu.B_IN = b; bu.VALID_IN = v; bu.CLR_IN = c;
        bs.A_IN = a; bs.B_IN = b; bs.VALID_IN = v; bs.CLR_IN = c;
    endtask

    task automatic step(logic [A_W-1:0] a, logic [B_W-1:0] b, bit v, bit c);
        set_inputs(a, b, v, c);
        if (v) model_sample(a, b, c);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_u_prod"},     64'(bu.PROD_OUT),   64'd0);
        check({tag, "_u_prod_vld"}, 64'(bu.PROD_VALID), 64'd0);
        check({tag, "_u_acc"},      64'(bu.ACC_OUT),    64'd0);
        check({tag, "_u_acc_vld"},  64'(bu.ACC_VALID),  64'd0);
        check({tag, "_s_prod"},     64'(bs.PROD_OUT),   64'd0);
        check({tag, "_s_prod_vld"}, 64'(bs.PROD_VALID), 64'd0);
        check({tag, "_s_acc"},      64'(bs.ACC_OUT),    64'd0);
        check({tag, "_s_acc_vld"},  64'(bs.ACC_VALID),  64'd0);
    endtask

    // Monitor: pop on every presented result, otherwise the output must hold.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bu.PROD_VALID) begin
                if (eq_pu.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u_prod_extra: got 0x%0h, expected no product", bu.PROD_OUT);
                end else begin
                    last_pu = eq_pu.pop_front() & PM;
                    check("u_prod", 64'(bu.PROD_OUT), last_pu);
                end
            end else check("u_prod_hold", 64'(bu.PROD_OUT), last_pu);

            if (bs.PROD_VALID) begin
                if (eq_ps.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL s_prod_extra: got 0x%0h, expected no product", bs.PROD_OUT);
                end else begin
                    last_ps = eq_ps.pop_front() & PM;
                    check("s_prod", 64'(bs.PROD_OUT), last_ps);
                end
            end else check("s_prod_hold", 64'(bs.PROD_OUT), last_ps);

            if (bu.ACC_VALID) begin
                if (eq_au.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u_acc_extra: got 0x%0h, expected no window", bu.ACC_OUT);
                end else begin
                    last_au = eq_au.pop_front() & AM;
                    check("u_acc", 64'(bu.ACC_OUT), last_au);
                end
            end else check("u_acc_hold", 64'(bu.ACC_OUT), last_au);

            if (bs.ACC_VALID) begin
                if (eq_as.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL s_acc_extra: got 0x%0h, expected no window", bs.ACC_OUT);
                end else begin
                    last_as = eq_as.pop_front() & AM;
                    check("s_acc", 64'(bs.ACC_OUT), last_as);
                end
            end else check("s_acc_hold", 64'(bs.ACC_OUT), last_as);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        set_inputs('0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        RST = 1'b0;

        // Latency: one sample, visible after exactly PIPE edges, single pulse.
        step(25'd512, 18'd512, 1'b1, 1'b0);
        check("lat_edge1_vld", 64'(bu.PROD_VALID), 64'd0);
        idle(1);
        check("lat_edge2_vld", 64'(bu.PROD_VALID), 64'd0);
        idle(1);
        check("lat_edge3_vld", 64'(bu.PROD_VALID), 64'd1);
        check("lat_edge3_prod", 64'(bu.PROD_OUT), 64'h40000);
        idle(1);
        check("lat_edge4_vld", 64'(bu.PROD_VALID), 64'd0);

        // Full-scale and signed corner products.
        step(25'd16777215, 18'd100000, 1'b1, 1'b0);
        step(25'h1FFFFFF,  18'h3FFFF,  1'b1, 1'b0);
        step(25'h1FFFFFF,  18'd2,      1'b1, 1'b0);
        step(25'h1FFFFFD,  18'h3FFFB,  1'b1, 1'b0);
        idle(2);

        // Back-to-back windows: clear on the first, next window without gap.
        for (int i = 0; i < TAPS; i++) step(25'd2020, 18'd2020, 1'b1, i == 0);
        for (int i = 0; i < TAPS; i++) step(25'd1, 18'd1, 1'b1, 1'b0);
        idle(5);

        // Window spread over bubbles.
        for (int i = 0; i < TAPS; i++) begin
            step(25'd1, 18'd1, 1'b1, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(5);

        // Clear arriving mid-window discards the partial sum.
        for (int i = 0; i < 4; i++) step(25'd5, 18'd7, 1'b1, 1'b0);
        for (int i = 0; i < TAPS; i++) step(25'd1, 18'd1, 1'b1, i == 0);
        idle(5);

        // Reset mid-window, then a fresh window.
        for (int i = 0; i < 5; i++) step(25'd3, 18'd3, 1'b1, 1'b0);
        set_inputs('0, '0, 1'b0, 1'b0);
        RST = 1'b1;
        flush_model();
        #1;
        check_zero("rst_mid");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(2);
        for (int i = 0; i < TAPS; i++) step(25'd3, 18'd3, 1'b1, 1'b0);
        idle(5);

        // Random traffic with bubbles, clears and full-scale operands.
        for (int i = 0; i < 400; i++) begin
            logic [A_W-1:0] a;
            logic [B_W-1:0] b;
            a = ($urandom_range(0, 7) == 0) ? {A_W{1'b1}} : A_W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? {B_W{1'b1}} : B_W'($urandom);
            step(a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end
        idle(PIPE + 4);

        check("drain_u_prod", 64'(eq_pu.size()), 64'd0);
        check("drain_s_prod", 64'(eq_ps.size()), 64'd0);
        check("drain_u_acc",  64'(eq_au.size()), 64'd0);
        check("drain_s_acc",  64'(eq_as.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
